// File: rtl/ctrl_pkg.sv
// Shared control-bundle types for the RV32I pipeline control unit.
package ctrl_pkg;

  localparam int unsigned RD_W = 5;

  localparam logic [4:0] OP_R     = 5'b01100;
  localparam logic [4:0] OP_I     = 5'b00100;
  localparam logic [4:0] OP_LW    = 5'b00000;
  localparam logic [4:0] OP_SW    = 5'b01000;
  localparam logic [4:0] OP_BEQ   = 5'b11000;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;

  typedef enum logic [2:0] {
    ALU_R     = 3'b000,
    ALU_BR    = 3'b001,
    ALU_MEM   = 3'b010,
    ALU_I     = 3'b011,
    ALU_UPPER = 3'b100,
    ALU_JUMP  = 3'b101
  } alu_op_e;

  typedef struct packed {
    alu_op_e           alu_op;
    logic              alu_src;
    logic [1:0]        auipc_lui;
    logic              branch;
    logic              jump;
    logic              mem_read;
    logic              mem_write;
    logic              reg_write;
    logic              mem_to_reg;
    logic [RD_W-1:0]   rd;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '{
    alu_op:     ALU_R,
    alu_src:    1'b0,
    auipc_lui:  2'b11,
    branch:     1'b0,
    jump:       1'b0,
    mem_read:   1'b0,
    mem_write:  1'b0,
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    rd:         '0
  };

endpackage

// File: rtl/main_decoder.sv
// Combinational RV32I main decoder: opcode -> control bundle plus illegal flag.
module main_decoder
  import ctrl_pkg::*;
#(
  parameter int HAS_JUMP = 1
) (
  input  logic [6:0]      opcode,
  input  logic [RD_W-1:0] rd,
  output ctrl_t           ctrl,
  output logic            illegal,
  output logic            uses_rs2
);

  always_comb begin
    ctrl      = CTRL_BUBBLE;
    ctrl.rd   = rd;
    illegal   = 1'b0;
    uses_rs2  = 1'b0;
    if (opcode[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (opcode[6:2])
        OP_R: begin
          ctrl.alu_op    = ALU_R;
          ctrl.reg_write = 1'b1;
          uses_rs2       = 1'b1;
        end
        OP_I: begin
          ctrl.alu_op    = ALU_I;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
        end
        OP_LW: begin
          ctrl.alu_op     = ALU_MEM;
          ctrl.alu_src    = 1'b1;
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
        end
        OP_SW: begin
          ctrl.alu_op    = ALU_MEM;
          ctrl.alu_src   = 1'b1;
          ctrl.mem_write = 1'b1;
          uses_rs2       = 1'b1;
        end
        OP_BEQ: begin
          ctrl.alu_op = ALU_BR;
          ctrl.branch = 1'b1;
          uses_rs2    = 1'b1;
        end
        OP_LUI: begin
          ctrl.alu_op    = ALU_UPPER;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.auipc_lui = 2'b01;
        end
        OP_AUIPC: begin
          ctrl.alu_op    = ALU_UPPER;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.auipc_lui = 2'b00;
        end
        OP_JAL: begin
          if (HAS_JUMP != 0) begin
            ctrl.alu_op    = ALU_JUMP;
            ctrl.jump      = 1'b1;
            ctrl.reg_write = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end
        OP_JALR: begin
          if (HAS_JUMP != 0) begin
            ctrl.alu_op    = ALU_JUMP;
            ctrl.jump      = 1'b1;
            ctrl.alu_src   = 1'b1;
            ctrl.reg_write = 1'b1;
          end else begin
            illegal = 1'b1;
          end
        end
        default: illegal = 1'b1;
      endcase
    end
    if (illegal) ctrl = CTRL_BUBBLE;
  end

endmodule

// File: rtl/pipe_control_unit.sv
// Pipelined control for the RV32I core: decode, ID/EX-EX/MEM-MEM/WB control
// registers, load-use / redirect / external-stall handling and a bubble counter.
module pipe_control_unit
  import ctrl_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int ALUOP_W  = 3,
  parameter int HAS_JUMP = 1,
  parameter int CNT_W    = 16
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic [XLEN-1:0]    instr_id,
  input  logic               instr_valid,
  input  logic               stall_ext,
  input  logic               redirect_ex,
  output logic [ALUOP_W-1:0] ex_ALUOp,
  output logic               ex_ALUSrc,
  output logic [1:0]         ex_AuipcLui,
  output logic               ex_Branch,
  output logic               ex_Jump,
  output logic               mem_MemRead,
  output logic               mem_MemWrite,
  output logic               wb_RegWrite,
  output logic               wb_MemtoReg,
  output logic [REG_AW-1:0]  wb_rd,
  output logic               stall_if,
  output logic               flush_if_id,
  output logic               illegal_id,
  output logic [CNT_W-1:0]   bubble_cnt
);

  ctrl_t           dec_ctrl;
  logic            dec_illegal;
  logic            dec_uses_rs2;
  ctrl_t           ex_q, mem_q, wb_q, ex_d;
  logic            load_use;
  logic            bubble;
  logic [RD_W-1:0] rs1, rs2;
  logic            unused_instr;

  assign rs1          = instr_id[19:15];
  assign rs2          = instr_id[24:20];
  assign unused_instr = ^{instr_id[XLEN-1:25], instr_id[14:12]};

  main_decoder #(.HAS_JUMP(HAS_JUMP)) u_dec (
    .opcode   (instr_id[6:0]),
    .rd       (instr_id[11:7]),
    .ctrl     (dec_ctrl),
    .illegal  (dec_illegal),
    .uses_rs2 (dec_uses_rs2)
  );

  // Redirect outranks load-use: the wrong-path consumer is squashed, so no stall is needed.
  always_comb begin
    load_use    = ex_q.mem_read && (ex_q.rd != '0) &&
                  ((ex_q.rd == rs1) || (dec_uses_rs2 && (ex_q.rd == rs2)));
    stall_if    = stall_ext || (!redirect_ex && load_use);
    flush_if_id = !stall_ext && redirect_ex;
    illegal_id  = dec_illegal;
    bubble      = redirect_ex || load_use || !instr_valid || dec_illegal;
    ex_d        = bubble ? CTRL_BUBBLE : dec_ctrl;
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      ex_q       <= CTRL_BUBBLE;
      mem_q      <= CTRL_BUBBLE;
      wb_q       <= CTRL_BUBBLE;
      bubble_cnt <= '0;
    end else if (!stall_ext) begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  assign ex_ALUOp     = ALUOP_W'(ex_q.alu_op);
  assign ex_ALUSrc    = ex_q.alu_src;
  assign ex_AuipcLui  = ex_q.auipc_lui;
  assign ex_Branch    = ex_q.branch;
  assign ex_Jump      = ex_q.jump;
  assign mem_MemRead  = mem_q.mem_read;
  assign mem_MemWrite = mem_q.mem_write;
  assign wb_RegWrite  = wb_q.reg_write;
  assign wb_MemtoReg  = wb_q.mem_to_reg;
  assign wb_rd        = REG_AW'(wb_q.rd);

endmodule

// File: tb/tb_pipe_control_unit.sv
// Directed scoreboard bench for pipe_control_unit (default build plus a
// HAS_JUMP=0 / CNT_W=2 build sharing the same stimulus).
module tb_pipe_control_unit;
  import ctrl_pkg::*;

  logic        CLK = 1'b0;
  logic        RST_n;
  logic [31:0] instr_id;
  logic        instr_valid, stall_ext, redirect_ex;

  logic [2:0]  ex_ALUOp;
  logic        ex_ALUSrc;
  logic [1:0]  ex_AuipcLui;
  logic        ex_Branch, ex_Jump, mem_MemRead, mem_MemWrite, wb_RegWrite, wb_MemtoReg;
  logic [4:0]  wb_rd;
  logic        stall_if, flush_if_id, illegal_id;
  logic [15:0] bubble_cnt;

  logic [2:0]  b_ex_ALUOp;
  logic        b_ex_ALUSrc;
  logic [1:0]  b_ex_AuipcLui;
  logic        b_ex_Branch, b_ex_Jump, b_mem_MemRead, b_mem_MemWrite, b_wb_RegWrite, b_wb_MemtoReg;
  logic [4:0]  b_wb_rd;
  logic        b_stall_if, b_flush_if_id, b_illegal_id;
  logic [1:0]  b_bubble_cnt;

  always #5 CLK = ~CLK;

  pipe_control_unit dut (
    .CLK(CLK), .RST_n(RST_n), .instr_id(instr_id), .instr_valid(instr_valid),
    .stall_ext(stall_ext), .redirect_ex(redirect_ex),
    .ex_ALUOp(ex_ALUOp), .ex_ALUSrc(ex_ALUSrc), .ex_AuipcLui(ex_AuipcLui),
    .ex_Branch(ex_Branch), .ex_Jump(ex_Jump), .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_rd(wb_rd), .stall_if(stall_if), .flush_if_id(flush_if_id),
    .illegal_id(illegal_id), .bubble_cnt(bubble_cnt)
  );

  pipe_control_unit #(.HAS_JUMP(0), .CNT_W(2)) dut_b (
    .CLK(CLK), .RST_n(RST_n), .instr_id(instr_id), .instr_valid(instr_valid),
    .stall_ext(stall_ext), .redirect_ex(redirect_ex),
    .ex_ALUOp(b_ex_ALUOp), .ex_ALUSrc(b_ex_ALUSrc), .ex_AuipcLui(b_ex_AuipcLui),
    .ex_Branch(b_ex_Branch), .ex_Jump(b_ex_Jump), .mem_MemRead(b_mem_MemRead),
    .mem_MemWrite(b_mem_MemWrite), .wb_RegWrite(b_wb_RegWrite), .wb_MemtoReg(b_wb_MemtoReg),
    .wb_rd(b_wb_rd), .stall_if(b_stall_if), .flush_if_id(b_flush_if_id),
    .illegal_id(b_illegal_id), .bubble_cnt(b_bubble_cnt)
  );

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] ADDI_X1  = 32'h0050_0093; // addi x1,x0,5 (rs2 field = 5)
  localparam logic [31:0] LW_X5    = 32'h0001_2283; // lw x5,0(x2)
  localparam logic [31:0] LW_X0    = 32'h0001_2003; // lw x0,0(x2)
  localparam logic [31:0] ADD_DEP  = 32'h0072_8333; // add x6,x5,x7
  localparam logic [31:0] ADD_X0   = 32'h0000_0333; // add x6,x0,x0
  localparam logic [31:0] ADDI_DEP = 32'h0012_8393; // addi x7,x5,1
  localparam logic [31:0] SW_DEP   = 32'h0051_2023; // sw x5,0(x2)
  localparam logic [31:0] BEQ_X    = 32'h0020_8063; // beq x1,x2,0
  localparam logic [31:0] LUI_X3   = 32'h1234_51B7;
  localparam logic [31:0] AUIPC_X4 = 32'h0000_0217;
  localparam logic [31:0] JAL_X1   = 32'h0000_00EF;
  localparam logic [31:0] JALR_X1  = 32'h0001_00E7;
  localparam logic [31:0] ECALL    = 32'h0000_0073;
  localparam logic [31:0] BAD_LOW  = 32'h0050_0090;

  int    ntests = 0;
  int    nfail  = 0;
  int    stepno = 0;
  int    cnt_a  = 0;
  int    cnt_b  = 0;
  ctrl_t exp_q[$];
  ctrl_t ex_exp, mem_exp, wb_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s@%0d observed=%0h expected=%0h", tag, stepno, obs, exp);
    end
  endtask

  // Expected bundle for a legal instruction with jumps enabled, straight from the opcode table.
  function automatic ctrl_t bdec(input logic [31:0] i);
    ctrl_t c;
    c    = CTRL_BUBBLE;
    c.rd = i[11:7];
    case (i[6:0])
      7'b0110011: begin c.alu_op = ALU_R; c.reg_write = 1'b1; end
      7'b0010011: begin c.alu_op = ALU_I; c.alu_src = 1'b1; c.reg_write = 1'b1; end
      7'b0000011: begin c.alu_op = ALU_MEM; c.alu_src = 1'b1; c.mem_read = 1'b1;
                        c.mem_to_reg = 1'b1; c.reg_write = 1'b1; end
      7'b0100011: begin c.alu_op = ALU_MEM; c.alu_src = 1'b1; c.mem_write = 1'b1; end
      7'b1100011: begin c.alu_op = ALU_BR; c.branch = 1'b1; end
      7'b0110111: begin c.alu_op = ALU_UPPER; c.alu_src = 1'b1; c.reg_write = 1'b1;
                        c.auipc_lui = 2'b01; end
      7'b0010111: begin c.alu_op = ALU_UPPER; c.alu_src = 1'b1; c.reg_write = 1'b1;
                        c.auipc_lui = 2'b00; end
      7'b1101111: begin c.alu_op = ALU_JUMP; c.jump = 1'b1; c.reg_write = 1'b1; end
      7'b1100111: begin c.alu_op = ALU_JUMP; c.jump = 1'b1; c.alu_src = 1'b1;
                        c.reg_write = 1'b1; end
      default:    c = CTRL_BUBBLE;
    endcase
    return c;
  endfunction

  function automatic bit is_jump(input logic [31:0] i);
    return (i[6:0] == 7'b1101111) || (i[6:0] == 7'b1100111);
  endfunction

  task automatic check_pipe();
    chk("ex_ALUOp",     32'(ex_ALUOp),     32'(ex_exp.alu_op));
    chk("ex_ALUSrc",    32'(ex_ALUSrc),    32'(ex_exp.alu_src));
    chk("ex_AuipcLui",  32'(ex_AuipcLui),  32'(ex_exp.auipc_lui));
    chk("ex_Branch",    32'(ex_Branch),    32'(ex_exp.branch));
    chk("ex_Jump",      32'(ex_Jump),      32'(ex_exp.jump));
    chk("mem_MemRead",  32'(mem_MemRead),  32'(mem_exp.mem_read));
    chk("mem_MemWrite", 32'(mem_MemWrite), 32'(mem_exp.mem_write));
    chk("wb_RegWrite",  32'(wb_RegWrite),  32'(wb_exp.reg_write));
    chk("wb_MemtoReg",  32'(wb_MemtoReg),  32'(wb_exp.mem_to_reg));
    chk("wb_rd",        32'(wb_rd),        32'(wb_exp.rd));
    chk("bubble_cnt",   32'(bubble_cnt),   32'(cnt_a));
    chk("b_bubble_cnt", 32'(b_bubble_cnt), 32'(cnt_b));
  endtask

  task automatic model_reset();
    exp_q.delete();
    ex_exp  = CTRL_BUBBLE;
    mem_exp = CTRL_BUBBLE;
    wb_exp  = CTRL_BUBBLE;
    cnt_a   = 0;
    cnt_b   = 0;
  endtask

  // One cycle: drive at negedge, check combinational outputs, clock, check registered outputs.
  task automatic step(input logic [31:0] ins, input logic v, input logic redir, input logic st,
                      input logic exp_bub, input logic exp_stall, input logic exp_flush,
                      input logic exp_ill);
    logic b_bub;
    stepno++;
    instr_id    = ins;
    instr_valid = v;
    redirect_ex = redir;
    stall_ext   = st;
    #1;
    chk("stall_if",     32'(stall_if),     32'(exp_stall));
    chk("flush_if_id",  32'(flush_if_id),  32'(exp_flush));
    chk("illegal_id",   32'(illegal_id),   32'(exp_ill));
    chk("b_illegal_id", 32'(b_illegal_id), 32'(exp_ill || is_jump(ins)));
    b_bub = exp_bub || (is_jump(ins) && (ins[1:0] == 2'b11));
    if (!st) begin
      exp_q.push_back(exp_bub ? CTRL_BUBBLE : bdec(ins));
      if (exp_bub && cnt_a != 65535) cnt_a++;
      if (b_bub && cnt_b != 3) cnt_b++;
    end
    @(posedge CLK);
    #1;
    if (!st) begin
      wb_exp  = mem_exp;
      mem_exp = ex_exp;
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        ex_exp = exp_q.pop_front();
      end
    end
    check_pipe();
    @(negedge CLK);
  endtask

  initial begin
    RST_n       = 1'b0;
    instr_id    = NOP;
    instr_valid = 1'b0;
    stall_ext   = 1'b0;
    redirect_ex = 1'b0;
    model_reset();
    repeat (2) @(negedge CLK);
    #1;
    check_pipe();
    chk("rst_stall_if",    32'(stall_if),    32'd0);
    chk("rst_flush_if_id", 32'(flush_if_id), 32'd0);
    chk("rst_illegal_id",  32'(illegal_id),  32'd0);
    @(negedge CLK);
    RST_n = 1'b1;

    //   ins       v  red st  bub stl fls ill
    // ADDI flows through EX, MEM, WB
    step(ADDI_X1,  1, 0, 0,   0,  0,  0,  0);
    step(NOP,      0, 0, 0,   1,  0,  0,  0);
    step(NOP,      0, 0, 0,   1,  0,  0,  0);
    step(NOP,      0, 0, 0,   1,  0,  0,  0);
    // load-use on rs1/rs2: one stall, one bubble, consumer retried
    step(LW_X5,    1, 0, 0,   0,  0,  0,  0);
    step(ADD_DEP,  1, 0, 0,   1,  1,  0,  0);
    step(ADD_DEP,  1, 0, 0,   0,  0,  0,  0);
    step(LW_X5,    1, 0, 0,   0,  0,  0,  0);
    step(ADDI_DEP, 1, 0, 0,   1,  1,  0,  0);
    step(ADDI_DEP, 1, 0, 0,   0,  0,  0,  0);
    step(LW_X5,    1, 0, 0,   0,  0,  0,  0);
    step(SW_DEP,   1, 0, 0,   1,  1,  0,  0);
    step(SW_DEP,   1, 0, 0,   0,  0,  0,  0);
    // I-type's rs2 field equal to rd must not stall
    step(LW_X5,    1, 0, 0,   0,  0,  0,  0);
    step(ADDI_X1,  1, 0, 0,   0,  0,  0,  0);
    // load to x0 never stalls
    step(LW_X0,    1, 0, 0,   0,  0,  0,  0);
    step(ADD_X0,   1, 0, 0,   0,  0,  0,  0);
    // redirect overrides load-use
    step(LW_X5,    1, 0, 0,   0,  0,  0,  0);
    step(ADD_DEP,  1, 1, 0,   1,  0,  1,  0);
    step(BEQ_X,    1, 0, 0,   0,  0,  0,  0);
    // external stall freezes everything, including a pending redirect and hazard
    step(LUI_X3,   1, 0, 0,   0,  0,  0,  0);
    step(LW_X5,    1, 0, 0,   0,  0,  0,  0);
    step(ADD_DEP,  1, 0, 1,   1,  1,  0,  0);
    step(ADD_DEP,  1, 1, 1,   1,  1,  0,  0);
    step(ADD_DEP,  1, 0, 1,   1,  1,  0,  0);
    step(ADD_DEP,  1, 0, 0,   1,  1,  0,  0);
    step(ADD_DEP,  1, 0, 0,   0,  0,  0,  0);
    step(AUIPC_X4, 1, 0, 1,   0,  1,  0,  0);
    step(AUIPC_X4, 1, 0, 0,   0,  0,  0,  0);
    // illegal encodings, jumps (illegal only in the no-jump build)
    step(ECALL,    1, 0, 0,   1,  0,  0,  1);
    step(BAD_LOW,  1, 0, 0,   1,  0,  0,  1);
    step(JAL_X1,   1, 0, 0,   0,  0,  0,  0);
    step(JALR_X1,  1, 0, 0,   0,  0,  0,  0);
    step(ECALL,    0, 0, 0,   1,  0,  0,  1);
    step(NOP,      1, 0, 0,   0,  0,  0,  0);
    step(NOP,      1, 0, 0,   0,  0,  0,  0);
    step(NOP,      1, 0, 0,   0,  0,  0,  0);

    // asynchronous reset mid-stream clears every stage without a clock edge
    step(LW_X5,    1, 0, 0,   0,  0,  0,  0);
    step(LUI_X3,   1, 0, 0,   0,  0,  0,  0);
    #2;
    RST_n = 1'b0;
    #1;
    model_reset();
    stepno++;
    check_pipe();
    @(negedge CLK);
    RST_n = 1'b1;
    step(ADDI_X1,  1, 0, 0,   0,  0,  0,  0);
    step(NOP,      1, 0, 0,   0,  0,  0,  0);
    step(NOP,      1, 0, 0,   0,  0,  0,  0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
